// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, requester IDs, window defaults.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

  localparam int unsigned DMEM_BASE_WORD = 268500992;
  localparam int unsigned DMEM_DEPTH     = 480;
  localparam int unsigned DMEM_BURST_MAX = 16;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational window check: flags misaligned or out-of-window byte addresses.
module dmem_addr_check
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned BASE_WORD   = DMEM_BASE_WORD,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH
) (
  input  logic [31:0] addr,
  output logic        err
);

  localparam logic [29:0] BASE  = BASE_WORD[29:0];
  // One extra bit so BASE+DEPTH near the top of the word space cannot wrap.
  localparam logic [30:0] LIMIT = {1'b0, BASE} + 31'(DEPTH_WORDS);

  assign err = (addr[1:0] != 2'b00)
            || (addr[31:2] < BASE)
            || ({1'b0, addr[31:2]} >= LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter with M1/M0 locked bursts in front of a single-port data memory.
// Grant is combinational; the response (rvalid/rdata/err) is registered one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned BASE_WORD   = DMEM_BASE_WORD,
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH,
  parameter int unsigned BURST_MAX   = DMEM_BURST_MAX
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(BURST_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

  arb_state_t    state, state_nxt;
  logic          rr_last, rr_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt;
  logic          any_gnt, win, win_we, win_lock, addr_err, own_req;

  // Grants are held off while reset is asserted so no access retires then.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset_n) begin
      case (state)
        ST_ARB: begin
          if (m0_req && m1_req) begin
            m0_gnt = (rr_last == ID_M1);
            m1_gnt = (rr_last == ID_M0);
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
        end
        ST_OWN0: m0_gnt = m0_req;
        ST_OWN1: m1_gnt = m1_req;
        default: ;
      endcase
    end
  end

  assign any_gnt   = m0_gnt | m1_gnt;
  assign win       = m1_gnt ? ID_M1 : ID_M0;
  assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign win_we    = m1_gnt ? m1_we    : m0_we;
  assign win_lock  = m1_gnt ? m1_lock  : m0_lock;
  assign mem_we    = any_gnt && win_we && !addr_err;

  dmem_addr_check #(
    .BASE_WORD   (BASE_WORD),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_addr_check (
    .addr (mem_addr),
    .err  (addr_err)
  );

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    rr_nxt    = any_gnt ? win : rr_last;
    own_req   = (state == ST_OWN1) ? m1_req : m0_req;
    case (state)
      ST_ARB: begin
        if (any_gnt && win_lock && !addr_err) begin
          state_nxt = m1_gnt ? ST_OWN1 : ST_OWN0;
          burst_nxt = CW'(1);
        end
      end
      ST_OWN0, ST_OWN1: begin
        // A grant at CNT_LAST is the BURST_MAX-th in a row, so ownership ends with it.
        if (!own_req || burst_cnt == CNT_MAX || !win_lock || addr_err
            || burst_cnt == CNT_LAST) begin
          state_nxt = ST_ARB;
          burst_nxt = '0;
        end else begin
          burst_nxt = burst_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_ARB;
        burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ARB;
      rr_last   <= ID_M1;
      burst_cnt <= '0;
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      rr_last   <= rr_nxt;
      burst_cnt <= burst_nxt;
      m0_rvalid <= m0_gnt;
      m0_err    <= m0_gnt && addr_err;
      m0_rdata  <= (m0_gnt && !win_we && !addr_err) ? mem_rdata : '0;
      m1_rvalid <= m1_gnt;
      m1_err    <= m1_gnt && addr_err;
      m1_rdata  <= (m1_gnt && !win_we && !addr_err) ? mem_rdata : '0;
    end
  end

endmodule
